// File: rtl/tpu_pkg.sv
// Shared TPU constants, FSM encodings and the clogb2 helper
// used by the accumulator writeback path.
package tpu_pkg;

    function automatic int clogb2(input int value);
        int v;
        v = value;
        for (clogb2 = 0; v > 0; clogb2++) begin
            v = v >> 1;
        end
    endfunction

    localparam int DATA_NUM         = 16;
    localparam int OUTPUT_DATA_SIZE = 8;
    localparam int ACC_DEPTH        = 64;
    localparam int ACC_ADDR_WIDTH   = clogb2(ACC_DEPTH - 1);
    localparam int UB_ADDR_WIDTH    = 8;
    localparam int ROW_DATA_WIDTH   = DATA_NUM * OUTPUT_DATA_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } drain_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that soaks up rows already read from the
// accumulator while the downstream write channel is stalled.
module skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/acc_drain.sv
// Accumulator writeback: sweeps rows out of the accumulator,
// applies optional ReLU and streams them to the unified buffer.
module acc_drain
    import tpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ACC_ADDR_WIDTH-1:0] acc_base,
    input  logic [UB_ADDR_WIDTH-1:0]  ub_base,
    input  logic [ACC_ADDR_WIDTH:0]   row_cnt,
    input  logic                      relu_en,
    output logic                      busy,
    output logic                      done,
    output logic                      acc_enb,
    output logic [ACC_ADDR_WIDTH-1:0] acc_addrb,
    input  logic [ROW_DATA_WIDTH-1:0] acc_doutb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [UB_ADDR_WIDTH-1:0]  out_addr,
    output logic [ROW_DATA_WIDTH-1:0] out_data
);

    localparam int W = OUTPUT_DATA_SIZE;

    drain_state_e              state_q;
    drain_state_e              state_d;
    logic [ACC_ADDR_WIDTH-1:0] acc_base_q;
    logic [UB_ADDR_WIDTH-1:0]  ub_base_q;
    logic [ACC_ADDR_WIDTH:0]   row_cnt_q;
    logic [ACC_ADDR_WIDTH:0]   issued_q;
    logic [ACC_ADDR_WIDTH:0]   accepted_q;
    logic                      relu_q;
    logic                      inflight_q;
    logic [1:0]                occ;
    logic                      pop;
    logic                      launch;
    logic [ROW_DATA_WIDTH-1:0] relu_row;

    assign pop       = out_valid && out_ready;
    assign launch    = start && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_valid = (occ != 2'd0);
    assign acc_addrb = acc_base_q + issued_q[ACC_ADDR_WIDTH-1:0];
    assign out_addr  = ub_base_q + UB_ADDR_WIDTH'(accepted_q);

    // Never let buffered plus in-flight rows exceed the two FIFO slots.
    assign acc_enb = (state_q == DRAIN)
                  && (issued_q < row_cnt_q)
                  && (({1'b0, occ} + {2'b0, inflight_q})
                      < (3'd2 + {2'b0, pop}));

    always_comb begin
        relu_row = acc_doutb;
        for (int i = 0; i < DATA_NUM; i++) begin
            if (relu_q && acc_doutb[i*W + W-1]) begin
                relu_row[i*W +: W] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (row_cnt == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if ((accepted_q + {{ACC_ADDR_WIDTH{1'b0}}, pop})
                    == row_cnt_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_base_q <= '0;
            ub_base_q  <= '0;
            row_cnt_q  <= '0;
            relu_q     <= 1'b0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= acc_enb;
            if (launch) begin
                acc_base_q <= acc_base;
                ub_base_q  <= ub_base;
                row_cnt_q  <= row_cnt;
                relu_q     <= relu_en;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (acc_enb) begin
                    issued_q <= issued_q + 1'b1;
                end
                if (pop) begin
                    accepted_q <= accepted_q + 1'b1;
                end
            end
        end
    end

    skid_fifo2 #(
        .WIDTH(ROW_DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .pop  (pop),
        .din  (relu_row),
        .dout (out_data),
        .count(occ)
    );

endmodule
